// File: rtl/pe_dbg_pkg.sv
// Shared types and helpers for the PE debug readout engine.
package pe_dbg_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic int idxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_mask_next.sv
// Priority finder: lowest set mask bit strictly above cur_i, or the lowest set
// bit overall when from_start_i is high.
module pe_mask_next
  import pe_dbg_pkg::*;
#(
  parameter int NUM_PE   = 4,
  parameter int PE_IDX_W = idxWidth(NUM_PE)
) (
  input  logic [NUM_PE-1:0]   mask_i,
  input  logic [PE_IDX_W-1:0] cur_i,
  input  logic                from_start_i,
  output logic [PE_IDX_W-1:0] next_o,
  output logic                found_o
);

  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int p = NUM_PE - 1; p >= 0; p--) begin
      if (mask_i[p] && (from_start_i || (p > int'(cur_i)))) begin
        next_o  = PE_IDX_W'(p);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_regfile_scan.sv
// Debug readout engine: snapshots all PE register files in one cycle and
// streams the words of the enabled PEs over a valid/ready channel.
module pe_regfile_scan
  import pe_dbg_pkg::*;
#(
  parameter int NUM_PE    = 4,
  parameter int REG_SIZE  = 4,
  parameter int DATA_W    = 16,
  parameter int PE_IDX_W  = idxWidth(NUM_PE),
  parameter int REG_IDX_W = idxWidth(REG_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              snap_req,
  input  logic [NUM_PE-1:0]                 pe_mask,
  input  logic [NUM_PE*REG_SIZE*DATA_W-1:0] regfile_flat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [PE_IDX_W-1:0]               out_pe,
  output logic [REG_IDX_W-1:0]              out_reg,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              snap_dropped
);

  state_e                              state_q;
  logic [PE_IDX_W-1:0]                 pe_q;
  logic [REG_IDX_W-1:0]                reg_q;
  logic [NUM_PE-1:0]                   mask_q;
  logic                                done_q;
  logic                                dropped_q;
  logic [NUM_PE*REG_SIZE*DATA_W-1:0]   shadow_q;

  logic [PE_IDX_W-1:0] firstPe;
  logic                firstFound;
  logic [PE_IDX_W-1:0] nextPe;
  logic                nextFound;
  logic                regAtEnd;
  logic                isLast;
  logic                accept;
  logic                streaming;
  int unsigned         wordIdx;

  pe_mask_next #(.NUM_PE(NUM_PE), .PE_IDX_W(PE_IDX_W)) u_first (
    .mask_i       (pe_mask),
    .cur_i        ('0),
    .from_start_i (1'b1),
    .next_o       (firstPe),
    .found_o      (firstFound)
  );

  pe_mask_next #(.NUM_PE(NUM_PE), .PE_IDX_W(PE_IDX_W)) u_advance (
    .mask_i       (mask_q),
    .cur_i        (pe_q),
    .from_start_i (1'b0),
    .next_o       (nextPe),
    .found_o      (nextFound)
  );

  assign streaming = (state_q == STREAM);
  assign accept    = (state_q == IDLE) && snap_req;
  assign regAtEnd  = (reg_q == REG_IDX_W'(REG_SIZE - 1));
  assign isLast    = regAtEnd && !nextFound;
  assign wordIdx   = int'(pe_q) * REG_SIZE + int'(reg_q);

  // Gating by state keeps the data bus at zero whenever nothing is offered.
  assign out_valid    = streaming;
  assign busy         = streaming;
  assign out_last     = streaming && isLast;
  assign out_data     = streaming ? shadow_q[wordIdx*DATA_W +: DATA_W] : '0;
  assign out_pe       = pe_q;
  assign out_reg      = reg_q;
  assign done         = done_q;
  assign snap_dropped = dropped_q;

  // The snapshot copy needs no reset; only an accepted request loads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_q <= regfile_flat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pe_q      <= '0;
      reg_q     <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snap_req) begin
            mask_q    <= pe_mask;
            dropped_q <= 1'b0;
            if (firstFound) begin
              state_q <= STREAM;
              pe_q    <= firstPe;
              reg_q   <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (snap_req) begin
            dropped_q <= 1'b1;
          end
          if (out_ready) begin
            if (isLast) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else if (regAtEnd) begin
              reg_q <= '0;
              pe_q  <= nextPe;
            end else begin
              reg_q <= reg_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_regfile_scan.sv
// Scoreboard bench for pe_regfile_scan: stimulus pushes expected words, a
// negedge monitor pops and compares every handshaked word.
module tb_pe_regfile_scan;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  pe;
    logic [1:0]  rg;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          snapReq;
  logic [3:0]    peMask;
  logic [255:0]  regfileFlat;
  logic          outReady;
  logic          outValid;
  logic [15:0]   outData;
  logic [1:0]    outPe;
  logic [1:0]    outReg;
  logic          outLast;
  logic          busy;
  logic          done;
  logic          snapDropped;

  logic          sReq;
  logic          sMask;
  logic [15:0]   sRegfile;
  logic          sReady;
  logic          sValid;
  logic [15:0]   sData;
  logic          sPe;
  logic          sReg;
  logic          sLast;
  logic          sBusy;
  logic          sDone;
  logic          sDropped;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            busyCycles = 0;
  bit            randomReady = 1'b0;
  bit            prevStall = 1'b0;
  logic [20:0]   prevHold;
  bit            seen;

  always #5 clk = ~clk;

  pe_regfile_scan #(.NUM_PE(4), .REG_SIZE(4), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .snap_req     (snapReq),
    .pe_mask      (peMask),
    .regfile_flat (regfileFlat),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_data     (outData),
    .out_pe       (outPe),
    .out_reg      (outReg),
    .out_last     (outLast),
    .busy         (busy),
    .done         (done),
    .snap_dropped (snapDropped)
  );

  pe_regfile_scan #(.NUM_PE(1), .REG_SIZE(1), .DATA_W(16)) dutSmall (
    .clk          (clk),
    .rst          (rst),
    .snap_req     (sReq),
    .pe_mask      (sMask),
    .regfile_flat (sRegfile),
    .out_valid    (sValid),
    .out_ready    (sReady),
    .out_data     (sData),
    .out_pe       (sPe),
    .out_reg      (sReg),
    .out_last     (sLast),
    .busy         (sBusy),
    .done         (sDone),
    .snap_dropped (sDropped)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic fillRegfile(input logic [15:0] base);
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 4; r++)
        regfileFlat[(p*4+r)*16 +: 16] = base + 16'(p*16 + r);
  endtask

  // Reference order: ascending enabled PEs, registers 0..3, last on top PE reg 3.
  task automatic pushSnapshot(input logic [3:0] mask, input logic [15:0] base);
    int topPe;
    exp_t e;
    topPe = -1;
    for (int p = 0; p < 4; p++) if (mask[p]) topPe = p;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin
        for (int r = 0; r < 4; r++) begin
          e.data = base + 16'(p*16 + r);
          e.pe   = 2'(p);
          e.rg   = 2'(r);
          e.last = (p == topPe) && (r == 3);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] base);
    @(posedge clk);
    #1;
    peMask = mask;
    fillRegfile(base);
    snapReq = 1'b1;
    @(posedge clk);
    #1;
    snapReq = 1'b0;
  endtask

  task automatic waitDone(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
  endtask

  // Monitor: pops one expected word per handshake and checks hold under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("holdValid", 32'(outValid), 32'd1);
        checkOutput("holdWord", 32'({outData, outPe, outReg, outLast}), 32'(prevHold));
      end
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedWord actual pe=%0d reg=%0d data=0x%0h required none",
                   outPe, outReg, outData);
        end else begin
          e = sb.pop_front();
          checkOutput("wordData", 32'(outData), 32'(e.data));
          checkOutput("wordPe", 32'(outPe), 32'(e.pe));
          checkOutput("wordReg", 32'(outReg), 32'(e.rg));
          checkOutput("wordLast", 32'(outLast), 32'(e.last));
        end
      end
      prevStall = outValid && !outReady;
      prevHold  = {outData, outPe, outReg, outLast};
      if (busy) busyCycles++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomReady) outReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; snapReq = 1'b0; peMask = '0; regfileFlat = '0; outReady = 1'b1;
    sReq = 1'b0; sMask = 1'b1; sRegfile = 16'hABCD; sReady = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetState", 32'({outValid, outData, outPe, outReg, outLast, busy, done, snapDropped}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full mask, ready held high.
    busyCycles = 0;
    pushSnapshot(4'hF, 16'h0000);
    applyStimulus(4'hF, 16'h0000);
    waitDone(100, seen);
    checkOutput("fullDoneSeen", 32'(seen), 32'd1);
    checkOutput("fullDoneBusy", 32'(busy), 32'd0);
    checkOutput("fullDoneValid", 32'(outValid), 32'd0);
    checkOutput("fullBusyCycles", 32'(busyCycles), 32'd16);
    checkOutput("fullDrained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    checkOutput("donePulse", 32'(done), 32'd0);

    // Sparse mask: PE1 then PE3 with no bubble between them.
    busyCycles = 0;
    pushSnapshot(4'b1010, 16'h0000);
    applyStimulus(4'b1010, 16'h0000);
    waitDone(100, seen);
    checkOutput("sparseDoneSeen", 32'(seen), 32'd1);
    checkOutput("sparseBusyCycles", 32'(busyCycles), 32'd8);
    checkOutput("sparseDrained", 32'(sb.size()), 32'd0);

    // Random backpressure and live regfile changes mid-stream.
    randomReady = 1'b1;
    pushSnapshot(4'hF, 16'h0100);
    applyStimulus(4'hF, 16'h0100);
    repeat (5) @(negedge clk);
    fillRegfile(16'h5500);
    waitDone(400, seen);
    randomReady = 1'b0;
    checkOutput("bpDoneSeen", 32'(seen), 32'd1);
    checkOutput("bpDrained", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1 outReady = 1'b1;

    // Request during stream is dropped; request in the done cycle is accepted.
    pushSnapshot(4'hF, 16'h0200);
    applyStimulus(4'hF, 16'h0200);
    repeat (3) @(negedge clk);
    snapReq = 1'b1;
    @(negedge clk);
    snapReq = 1'b0;
    waitDone(100, seen);
    checkOutput("dropDoneSeen", 32'(seen), 32'd1);
    checkOutput("droppedSticky", 32'(snapDropped), 32'd1);
    checkOutput("dropDrained", 32'(sb.size()), 32'd0);
    busyCycles = 0;
    peMask = 4'b0011;
    fillRegfile(16'h0300);
    pushSnapshot(4'b0011, 16'h0300);
    snapReq = 1'b1;
    @(posedge clk);
    #1 snapReq = 1'b0;
    checkOutput("droppedCleared", 32'(snapDropped), 32'd0);
    checkOutput("backToBackBusy", 32'(busy), 32'd1);
    waitDone(100, seen);
    checkOutput("b2bDoneSeen", 32'(seen), 32'd1);
    checkOutput("b2bBusyCycles", 32'(busyCycles), 32'd8);
    checkOutput("b2bDrained", 32'(sb.size()), 32'd0);

    // Empty mask: done only.
    busyCycles = 0;
    applyStimulus(4'b0000, 16'h0000);
    @(negedge clk);
    checkOutput("emptyDone", 32'(done), 32'd1);
    checkOutput("emptyValid", 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput("emptyDoneOnce", 32'(done), 32'd0);
    checkOutput("emptyBusyCycles", 32'(busyCycles), 32'd0);

    // Asynchronous reset mid-stream.
    pushSnapshot(4'hF, 16'h0400);
    applyStimulus(4'hF, 16'h0400);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncReset", 32'({outValid, outData, outPe, outReg, outLast, busy, done, snapDropped}), 32'd0);
    sb.delete();
    @(negedge clk);
    checkOutput("resetNoDone", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postResetDone", 32'(done), 32'd0);
      checkOutput("postResetValid", 32'(outValid), 32'd0);
    end

    // Single PE, single register instance.
    @(posedge clk);
    #1 sReq = 1'b1;
    @(posedge clk);
    #1 sReq = 1'b0;
    @(negedge clk);
    checkOutput("smallValid", 32'(sValid), 32'd1);
    checkOutput("smallData", 32'(sData), 32'hABCD);
    checkOutput("smallLast", 32'(sLast), 32'd1);
    checkOutput("smallIndex", 32'({sPe, sReg}), 32'd0);
    @(negedge clk);
    checkOutput("smallDone", 32'(sDone), 32'd1);
    checkOutput("smallIdle", 32'({sValid, sBusy}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
